mem_readout_scanner: RTL and testbench

MEM_READOUT_SCANNER -- requirements
Module: mem_readout_scanner

---
 rtl/mem_readout_scanner.sv | 150 +++++++++++++++
 tb/tb_mem_readout_scanner.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_readout_scanner.sv
// mem_readout_scanner: walks a contiguous region of a synchronous-read memory
// and presents it as beats on a valid/ready stream. Scalar mode fetches one
// word per beat into lane 0; vector mode fetches LANES consecutive words per
// beat. Each scan is armed by a start pulse that latches mode, base address
// and beat count.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; mode/base_addr/count sampled here only
// READ    | issuing read strobes and capturing returned words into lanes
// PRESENT | beat held on out_data/out_valid until the consumer accepts it
// DONE    | single-cycle done pulse, then back to IDLE

module mem_readout_scanner #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 24,
    parameter int LANES  = 6,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      mode,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [CNT_W-1:0]          count,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_rd_en,
    input  logic [DATA_W-1:0]         mem_q,
    output logic [LANES*DATA_W-1:0]   out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);

    localparam int IDX_W = 4;
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             state;
    logic               mode_r;
    logic [CNT_W-1:0]   beats_left;
    logic [IDX_W-1:0]   rd_left;
    logic [IDX_W-1:0]   cap_idx;
    logic               q_vld;
    logic [IDX_W-1:0]   cap_last;

    // Index of the final lane of a beat for the latched mode.
    always_comb begin
        cap_last = mode_r ? LAST_LANE : '0;
    end

    // Scan sequencer: issues reads, captures lanes, and handshakes beats out.
    // mem_addr is left on the last word read, so the next beat starts at +1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mode_r     <= 1'b0;
            beats_left <= '0;
            rd_left    <= '0;
            cap_idx    <= '0;
            q_vld      <= 1'b0;
            mem_addr   <= '0;
            mem_rd_en  <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // mem_q carries valid data exactly one cycle after a strobe
            q_vld <= mem_rd_en;
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mode_r <= mode;
                        busy   <= 1'b1;
                        if (count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= READ;
                            beats_left <= count;
                            mem_rd_en  <= 1'b1;
                            mem_addr   <= base_addr;
                            rd_left    <= mode ? LAST_LANE : '0;
                            cap_idx    <= '0;
                            out_data   <= '0;
                        end
                    end
                end
                READ: begin
                    if (rd_left != '0) begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                        rd_left  <= rd_left - IDX_W'(1);
                    end else begin
                        mem_rd_en <= 1'b0;
                    end
                    if (q_vld) begin
                        for (int i = 0; i < LANES; i++) begin
                            if (cap_idx == IDX_W'(i)) begin
                                out_data[i*DATA_W +: DATA_W] <= mem_q;
                            end
                        end
                        cap_idx <= cap_idx + IDX_W'(1);
                        if (cap_idx == cap_last) begin
                            state     <= PRESENT;
                            out_valid <= 1'b1;
                            out_last  <= (beats_left == CNT_W'(1));
                        end
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (beats_left == CNT_W'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            beats_left <= beats_left - CNT_W'(1);
                            state      <= READ;
                            mem_rd_en  <= 1'b1;
                            mem_addr   <= mem_addr + ADDR_W'(1);
                            rd_left    <= cap_last;
                            cap_idx    <= '0;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_readout_scanner.sv
// Bench for mem_readout_scanner: a default-parameter instance (6 lanes,
// 24-bit addresses) and a small instance (4 lanes, 4-bit addresses) for
// address wrap. Expected beats come from the memory contents and scan
// arithmetic (address = base + beat*N + lane, modulo the address space).

module tb_mem_readout_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1, mode, out_ready;
    logic [23:0] base_addr;
    logic [15:0] count;

    logic [23:0] addr0;
    logic        rd_en0, valid0, last0, busy0, done0;
    logic [15:0] q0;
    logic [95:0] data0;

    logic [3:0]  addr1;
    logic        rd_en1, valid1, last1, busy1, done1;
    logic [15:0] q1;
    logic [63:0] data1;

    logic [15:0] mem [256];

    logic         sel;
    logic [23:0]  o_addr;
    logic [127:0] o_data;
    logic         o_rd_en, o_valid, o_last, o_busy, o_done;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mem_readout_scanner dut0 (
        .clk(clk), .rst(rst), .start(start0), .mode(mode),
        .base_addr(base_addr), .count(count),
        .mem_addr(addr0), .mem_rd_en(rd_en0), .mem_q(q0),
        .out_data(data0), .out_valid(valid0), .out_ready(out_ready),
        .out_last(last0), .busy(busy0), .done(done0)
    );

    mem_readout_scanner #(.DATA_W(16), .ADDR_W(4), .LANES(4), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode),
        .base_addr(base_addr[3:0]), .count(count),
        .mem_addr(addr1), .mem_rd_en(rd_en1), .mem_q(q1),
        .out_data(data1), .out_valid(valid1), .out_ready(out_ready),
        .out_last(last1), .busy(busy1), .done(done1)
    );

    // Synchronous-read memories; garbage on mem_q when not strobed.
    always @(posedge clk) begin
        q0 <= rd_en0 ? mem[addr0[7:0]] : 16'($urandom);
        q1 <= rd_en1 ? mem[{4'b0, addr1}] : 16'($urandom);
    end

    assign o_addr  = sel ? {20'b0, addr1} : addr0;
    assign o_data  = sel ? {64'b0, data1} : {32'b0, data0};
    assign o_rd_en = sel ? rd_en1 : rd_en0;
    assign o_valid = sel ? valid1 : valid0;
    assign o_last  = sel ? last1  : last0;
    assign o_busy  = sel ? busy1  : busy0;
    assign o_done  = sel ? done1  : done0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_start(input bit s, input logic v);
        if (s) start1 = v;
        else   start0 = v;
    endtask

    task automatic scramble();
        mode      = 1'($urandom);
        base_addr = 24'($urandom);
        count     = 16'($urandom_range(0, 7));
    endtask

    // One scan: s selects the instance, rmode 0=ready high, 1=toggle, 2=random,
    // abort_beat>0 pulls reset while the given beat is being fetched.
    task automatic run_scan(input bit s, input bit m, input logic [23:0] b,
                            input int c, input int rmode, input int abort_beat);
        int lanes = s ? 4 : 6;
        int n = m ? lanes : 1;
        logic [23:0] mask = s ? 24'h00000F : 24'hFFFFFF;
        int nreads = 0, beat = 0, dones = 0, first_valid = -1;
        bit holding = 0, post_done = 0, finished = 0, aborted = 0, r;
        logic [127:0] held = '0;
        logic [127:0] exp;
        logic [23:0] a;

        sel = s;
        @(negedge clk);
        mode = m; base_addr = b; count = 16'(c); out_ready = 1'b0;
        set_start(s, 1'b1);
        @(posedge clk);
        #1;
        set_start(s, 1'b0);
        scramble();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (abort_beat > 0 && beat == abort_beat - 1 && !o_valid) begin
                rst = 1'b0;
                #1;
                check("rst_outputs", {o_addr, o_rd_en, o_valid, o_last, o_busy, o_done}, '0);
                check("rst_data", o_data, '0);
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    check("rst_no_done", {o_done, o_busy}, 2'b00);
                end
                rst = 1'b1;
                aborted = 1;
                break;
            end
            if (o_rd_en) begin
                a = (b + 24'(nreads)) & mask;
                check("rd_addr", o_addr, a);
                nreads++;
            end
            if (o_valid) check("rd_en_in_present", o_rd_en, 1'b0);
            check("last", o_last, o_valid && (beat == c - 1));
            if (o_valid && first_valid < 0) begin
                first_valid = k;
                check("latency", k, m ? lanes + 1 : 2);
            end
            if (holding) begin
                check("hold_valid", o_valid, 1'b1);
                check("hold_data", o_data, held);
            end
            if (post_done) begin
                check("busy_after_done", o_busy, 1'b0);
                finished = 1;
                break;
            end else if (o_done) begin
                dones++;
                check("done_beats", beat, c);
                check("busy_in_done", o_busy, 1'b1);
                if (c == 0) check("done_time", k, 0);
                post_done = 1;
            end else begin
                check("busy", o_busy, 1'b1);
            end
            r = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'(k % 2) : 1'($urandom);
            out_ready = r;
            holding = 0;
            if (o_valid && r) begin
                exp = '0;
                for (int i = 0; i < n; i++) begin
                    a = (b + 24'(beat * n + i)) & mask;
                    exp[i*16 +: 16] = mem[a[7:0]];
                end
                check("beat_data", o_data, exp);
                beat++;
            end else if (o_valid) begin
                holding = 1;
                held = o_data;
            end
            set_start(s, 1'($urandom_range(0, 3) == 0));
            scramble();
        end
        set_start(s, 1'b0);
        out_ready = 1'b0;
        if (!aborted) begin
            if (!finished) check("timeout", 0, 1);
            check("done_count", dones, 1);
            check("beat_count", beat, c);
            check("read_count", nreads, c * n);
            if (c == 0) check("valid_never", first_valid, -1);
        end
    endtask

    initial begin
        rst = 1'b0;
        start0 = 1'b0; start1 = 1'b0; mode = 1'b0; out_ready = 1'b0;
        base_addr = '0; count = '0; sel = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[4] = 16'd5;  mem[5] = 16'd7;  mem[6] = 16'd13;
        mem[7] = 16'd19; mem[8] = 16'd23; mem[9] = 16'd24;

        repeat (2) @(negedge clk);
        check("reset_dut0", {addr0, rd_en0, valid0, last0, busy0, done0}, '0);
        check("reset_data0", data0, '0);
        check("reset_dut1", {addr1, rd_en1, valid1, last1, busy1, done1}, '0);
        check("reset_data1", data1, '0);
        @(negedge clk);
        rst = 1'b1;

        run_scan(0, 0, 24'd4, 6, 0, 0);
        run_scan(0, 1, 24'd4, 1, 0, 0);
        run_scan(0, 0, 24'd4, 3, 1, 0);
        run_scan(1, 1, 24'd14, 1, 0, 0);
        run_scan(0, 0, 24'd7, 0, 0, 0);
        run_scan(0, 1, 24'hFFFFFC, 2, 2, 0);
        run_scan(1, 0, 24'd15, 3, 2, 0);
        run_scan(0, 0, 24'd4, 6, 0, 2);
        run_scan(0, 0, 24'd10, 1, 0, 0);
        for (int t = 0; t < 8; t++) begin
            run_scan(1'($urandom), 1'($urandom), 24'($urandom_range(0, 250)),
                     $urandom_range(1, 5), 2, 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
